// File: rtl/imem_arbiter_if.sv
// ---------------------------------------------------------------------------
// imem_arbiter_if
// Purpose : bundles the CPU fetch port, the program-loader handshake and the
//           instruction-memory port of the instruction-memory arbiter.
// Signals :
//   cpu_addr / cpu_data / cpu_stall     CPU fetch address, instruction, freeze
//   ld_start / ld_base / ld_count       burst request, first address, length
//   ld_valid / ld_data / ld_ready       loader word handshake
//   ld_done / words_written             burst-complete pulse, burst word count
//   mem_addr / mem_wdata / mem_we       instruction-memory write/read port
//   mem_rdata                           combinational memory read data
// Modports: slave  = the arbiter
//           master = the surroundings (CPU, loader and memory)
// ---------------------------------------------------------------------------
interface imem_arbiter_if #(
    parameter int bit_width  = 32,
    parameter int depth_log2 = 10
);
    logic [bit_width-1:0]  cpu_addr;
    logic [bit_width-1:0]  cpu_data;
    logic                  cpu_stall;
    logic                  ld_start;
    logic [depth_log2-1:0] ld_base;
    logic [depth_log2:0]   ld_count;
    logic                  ld_valid;
    logic [bit_width-1:0]  ld_data;
    logic                  ld_ready;
    logic                  ld_done;
    logic [depth_log2-1:0] mem_addr;
    logic [bit_width-1:0]  mem_wdata;
    logic                  mem_we;
    logic [bit_width-1:0]  mem_rdata;
    logic [depth_log2:0]   words_written;

    modport slave (
        input  cpu_addr, ld_start, ld_base, ld_count, ld_valid, ld_data, mem_rdata,
        output cpu_data, cpu_stall, ld_ready, ld_done,
               mem_addr, mem_wdata, mem_we, words_written
    );

    modport master (
        output cpu_addr, ld_start, ld_base, ld_count, ld_valid, ld_data, mem_rdata,
        input  cpu_data, cpu_stall, ld_ready, ld_done,
               mem_addr, mem_wdata, mem_we, words_written
    );
endinterface

// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
// Purpose : shares a single instruction-memory port between the CPU fetch
//           path and a program loader. While idle the CPU fetches with zero
//           latency straight through the memory. A load burst stalls the CPU,
//           feeds NOPs, and writes loader words to consecutive (wrapping)
//           addresses. It then spends one DONE cycle pulsing ld_done before
//           returning the port to the CPU.
// Ports   :
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - imem_arbiter_if.slave (CPU, loader and memory signals)
// ---------------------------------------------------------------------------
module imem_arbiter #(
    parameter int bit_width  = 32,
    parameter int depth_log2 = 10
) (
    input  logic           clk,
    input  logic           rst,
    imem_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // A burst can never usefully exceed the memory size, so longer requests
    // are clamped to 2^depth_log2 words.
    localparam logic [depth_log2:0] MAX_WORDS = {1'b1, {depth_log2{1'b0}}};

    logic [1:0]            r_state;
    logic [depth_log2-1:0] r_ptr;
    logic [depth_log2:0]   r_remaining;
    logic [depth_log2:0]   r_words_written;

    logic                  w_in_load;
    logic                  w_accept;
    logic [depth_log2:0]   w_count_clamped;

    assign w_in_load       = (r_state == S_LOAD);
    assign w_accept        = w_in_load & bus.ld_valid;
    assign w_count_clamped = bus.ld_count[depth_log2] ? MAX_WORDS : bus.ld_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_ptr           <= '0;
            r_remaining     <= '0;
            r_words_written <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.ld_start) begin
                        r_words_written <= '0;
                        if (bus.ld_count == '0) begin
                            // Empty burst: straight to the completion pulse.
                            r_state <= S_DONE;
                        end else begin
                            r_state     <= S_LOAD;
                            r_ptr       <= bus.ld_base;
                            r_remaining <= w_count_clamped;
                        end
                    end
                end
                S_LOAD: begin
                    // ld_start is deliberately not looked at here.
                    if (w_accept) begin
                        r_ptr           <= r_ptr + 1'b1;   // wraps at memory end
                        r_remaining     <= r_remaining - 1'b1;
                        r_words_written <= r_words_written + 1'b1;
                        if (r_remaining == {{depth_log2{1'b0}}, 1'b1}) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode is purely combinational so the IDLE fetch path
    // cpu_addr -> mem_addr -> mem_rdata -> cpu_data has no register in it.
    always_comb begin
        bus.mem_addr  = bus.cpu_addr[depth_log2-1:0];
        bus.cpu_data  = '0;
        bus.cpu_stall = 1'b1;
        bus.ld_ready  = 1'b0;
        bus.ld_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.cpu_data  = bus.mem_rdata;
                bus.cpu_stall = 1'b0;
            end
            S_LOAD: begin
                bus.mem_addr = r_ptr;
                bus.ld_ready = 1'b1;
            end
            S_DONE: begin
                bus.ld_done = 1'b1;
            end
            default: begin
                bus.cpu_stall = 1'b0;
            end
        endcase
    end

    assign bus.mem_we        = w_accept;
    assign bus.mem_wdata     = bus.ld_data;
    assign bus.words_written = r_words_written;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;
    localparam int BW = 32;
    localparam int DL = 10;
    localparam int NW = 1 << DL;

    logic clk;
    logic rst;

    imem_arbiter_if #(.bit_width(BW), .depth_log2(DL)) bus ();

    imem_arbiter #(.bit_width(BW), .depth_log2(DL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int a);
        if (a == 3) return 32'h0022202B;
        return 32'hC0DE0000 | 32'(a);
    endfunction

    // Instruction memory seen by the DUT: combinational read, clocked write.
    bit [31:0]   hmem     [NW];
    bit [NW-1:0] hwritten;
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            hmem[bus.mem_addr]     <= bus.mem_wdata;
            hwritten[bus.mem_addr] <= 1'b1;
        end
    end
    assign bus.mem_rdata = hwritten[bus.mem_addr] ? hmem[bus.mem_addr] : init_val(int'(bus.mem_addr));

    // Behavioural model: mode 0 = CPU owns memory, 1 = loading, 2 = completion cycle.
    int          m_mode    = 0;
    int          m_ptr     = 0;
    int          m_left    = 0;
    int          m_written = 0;
    bit [31:0]   shadow   [NW];
    bit [NW-1:0] swritten;

    function automatic logic [31:0] shadow_read(input int a);
        return swritten[a] ? shadow[a] : init_val(a);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode    <= 0;
            m_ptr     <= 0;
            m_left    <= 0;
            m_written <= 0;
        end else if (m_mode == 0) begin
            if (bus.ld_start) begin
                m_written <= 0;
                if (bus.ld_count == 0) begin
                    m_mode <= 2;
                end else begin
                    m_mode <= 1;
                    m_ptr  <= int'(bus.ld_base);
                    m_left <= (int'(bus.ld_count) > NW) ? NW : int'(bus.ld_count);
                end
            end
        end else if (m_mode == 1) begin
            if (bus.ld_valid) begin
                shadow[m_ptr]   <= bus.ld_data;
                swritten[m_ptr] <= 1'b1;
                m_ptr           <= (m_ptr + 1) % NW;
                m_left          <= m_left - 1;
                m_written       <= m_written + 1;
                if (m_left == 1) m_mode <= 2;
            end
        end else begin
            m_mode <= 0;
        end
    end

    // Per-cycle comparison against the model, on the inactive edge.
    always @(negedge clk) begin
        chk("cpu_stall", 64'(bus.cpu_stall), 64'(m_mode != 0));
        chk("ld_ready", 64'(bus.ld_ready), 64'(m_mode == 1));
        chk("ld_done", 64'(bus.ld_done), 64'(m_mode == 2));
        chk("mem_we", 64'(bus.mem_we), 64'((m_mode == 1) && bus.ld_valid));
        chk("words_written", 64'(bus.words_written), 64'(m_written));
        if (m_mode == 0) begin
            chk("idle_mem_addr", 64'(bus.mem_addr), 64'(bus.cpu_addr[DL-1:0]));
            chk("idle_cpu_data", 64'(bus.cpu_data), 64'(shadow_read(int'(bus.cpu_addr[DL-1:0]))));
        end
        if (m_mode == 1) begin
            chk("load_mem_addr", 64'(bus.mem_addr), 64'(m_ptr));
            chk("load_cpu_data", 64'(bus.cpu_data), 64'(0));
            if (bus.ld_valid) chk("load_wdata", 64'(bus.mem_wdata), 64'(bus.ld_data));
        end
    end

    task automatic start_burst(input int base, input int count);
        @(posedge clk); #1;
        bus.ld_start = 1'b1;
        bus.ld_base  = DL'(base);
        bus.ld_count = (DL+1)'(count);
        @(posedge clk); #1;
        bus.ld_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic fetch_check(input string name, input int a, input logic [31:0] exp);
        bus.cpu_addr = 32'(a);
        #1;
        chk(name, 64'(bus.cpu_data), 64'(exp));
    endtask

    initial begin
        rst          = 1'b1;
        bus.cpu_addr = 32'd3;
        bus.ld_start = 1'b0;
        bus.ld_base  = '0;
        bus.ld_count = '0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        idle_cycles(2);
        chk("reset_stall", 64'(bus.cpu_stall), 64'(0));
        chk("reset_words", 64'(bus.words_written), 64'(0));
        rst = 1'b0;
        idle_cycles(1);

        // Zero-latency fetch in idle.
        chk("fetch3_data", 64'(bus.cpu_data), 64'h0022202B);
        chk("fetch3_addr", 64'(bus.mem_addr), 64'd3);
        chk("fetch3_we", 64'(bus.mem_we), 64'd0);
        $display("txn fetch addr=3 data=%h", bus.cpu_data);

        // Three-word burst at 0.
        start_burst(0, 3);
        send_word(32'h2001000A);
        send_word(32'h2002FFFE);
        send_word(32'hFC000000);
        chk("b1_done", 64'(bus.ld_done), 64'd1);
        chk("b1_words", 64'(bus.words_written), 64'd3);
        idle_cycles(1);
        chk("b1_stall_after", 64'(bus.cpu_stall), 64'd0);
        chk("b1_done_after", 64'(bus.ld_done), 64'd0);
        fetch_check("b1_rd0", 0, 32'h2001000A);
        fetch_check("b1_rd1", 1, 32'h2002FFFE);
        fetch_check("b1_rd2", 2, 32'hFC000000);
        $display("txn burst base=0 count=3 words=%0d", bus.words_written);

        // Wrapping burst.
        start_burst(1022, 4);
        send_word(32'hAAAA0001);
        send_word(32'hAAAA0002);
        send_word(32'hAAAA0003);
        send_word(32'hAAAA0004);
        chk("b2_words", 64'(bus.words_written), 64'd4);
        idle_cycles(1);
        fetch_check("b2_rd1022", 1022, 32'hAAAA0001);
        fetch_check("b2_rd1023", 1023, 32'hAAAA0002);
        fetch_check("b2_rd0", 0, 32'hAAAA0003);
        fetch_check("b2_rd1", 1, 32'hAAAA0004);
        fetch_check("b2_rd2", 2, 32'hFC000000);
        $display("txn burst base=1022 count=4 words=%0d", bus.words_written);

        // Gapped burst with an ignored ld_start in the gap.
        start_burst(5, 2);
        send_word(32'h55550001);
        idle_cycles(2);
        bus.ld_start = 1'b1;
        bus.ld_base  = DL'(100);
        bus.ld_count = (DL+1)'(7);
        idle_cycles(1);
        bus.ld_start = 1'b0;
        idle_cycles(2);
        chk("b3_gap_stall", 64'(bus.cpu_stall), 64'd1);
        chk("b3_gap_data", 64'(bus.cpu_data), 64'd0);
        chk("b3_gap_words", 64'(bus.words_written), 64'd1);
        send_word(32'h55550002);
        chk("b3_done", 64'(bus.ld_done), 64'd1);
        chk("b3_words", 64'(bus.words_written), 64'd2);
        idle_cycles(1);
        fetch_check("b3_rd5", 5, 32'h55550001);
        fetch_check("b3_rd6", 6, 32'h55550002);
        fetch_check("b3_rd100", 100, init_val(100));
        $display("txn burst base=5 count=2 gapped words=%0d", bus.words_written);

        // Reset after one of four words.
        start_burst(200, 4);
        send_word(32'h11112222);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_stall", 64'(bus.cpu_stall), 64'd0);
        chk("rst_words", 64'(bus.words_written), 64'd0);
        chk("rst_ready", 64'(bus.ld_ready), 64'd0);
        chk("rst_we", 64'(bus.mem_we), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        fetch_check("rst_keep200", 200, 32'h11112222);
        fetch_check("rst_untouched201", 201, init_val(201));
        $display("txn reset mid-burst base=200 kept=%h", bus.cpu_data);

        // Empty burst.
        start_burst(50, 0);
        chk("b0_done", 64'(bus.ld_done), 64'd1);
        chk("b0_we", 64'(bus.mem_we), 64'd0);
        chk("b0_words", 64'(bus.words_written), 64'd0);
        idle_cycles(1);
        chk("b0_done_after", 64'(bus.ld_done), 64'd0);
        chk("b0_stall_after", 64'(bus.cpu_stall), 64'd0);
        fetch_check("b0_rd50", 50, init_val(50));
        $display("txn burst base=50 count=0 done");

        idle_cycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter: bit_width, default 32, instruction and address word width.
REQ-002 Parameter: depth_log2, default 10, instruction-memory address bits (1024 words).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cpu_addr  input  bit_width  fetch address from the CPU PC.
REQ-006 cpu_data  output  bit_width  instruction returned to the CPU.
REQ-007 cpu_stall  output  1  CPU shall freeze its PC and IF stage while this is high.
REQ-008 ld_start  input  1  one-cycle pulse requesting a program-load burst.
REQ-009 ld_base  input  depth_log2  first word address of the burst; sampled on the accepted ld_start.
REQ-010 ld_count  input  depth_log2+1  number of words in the burst; sampled on the accepted ld_start.
REQ-011 ld_valid / ld_data  input  1 / bit_width  loader word handshake.
REQ-012 ld_ready  output  1  arbiter accepts a loader word this cycle.
REQ-013 ld_done  output  1  one-cycle pulse marking burst completion.
REQ-014 mem_addr / mem_wdata / mem_we  output  depth_log2 / bit_width / 1  instruction-memory port.
REQ-015 mem_rdata  input  bit_width  combinational read data from the instruction memory.
REQ-016 words_written  output  depth_log2+1  words written in the current or last burst.

Function
REQ-017 The FSM shall have exactly three states: IDLE, LOAD, DONE.
REQ-018 IDLE: mem_addr = cpu_addr[depth_log2-1:0]; cpu_data = mem_rdata; mem_we = 0; cpu_stall = 0; ld_ready = 0.
REQ-019 IDLE + ld_start + ld_count != 0 -> LOAD; latch ptr = ld_base, remaining = min(ld_count, 2^depth_log2), words_written = 0.
REQ-020 IDLE + ld_start + ld_count == 0 -> DONE, with no memory write.
REQ-021 LOAD: cpu_stall = 1; ld_ready = 1; cpu_data = 32'h00000000 (NOP); mem_addr = ptr; mem_wdata = ld_data.
REQ-022 LOAD: mem_we = ld_valid & ld_ready (combinational); each accepted word increments ptr modulo 2^depth_log2 (1023 wraps to 0), decrements remaining, and increments words_written.
REQ-023 LOAD: remaining == 1 and a word is accepted -> DONE next cycle.
REQ-024 LOAD with ld_valid = 0: no write, no counter change; stay in LOAD for any number of idle cycles.
REQ-025 DONE: lasts exactly one cycle; ld_done = 1; cpu_stall = 1; ld_ready = 0; mem_we = 0; -> IDLE.
REQ-026 ld_start in LOAD or DONE shall be ignored; no re-latch of base or count.
REQ-027 Total fetch latency in IDLE shall be zero cycles (combinational path cpu_addr -> mem_rdata -> cpu_data).
REQ-028 words_written shall hold its value after DONE until the next accepted ld_start.

Reset
REQ-029 rst high at any time (including mid-LOAD) shall immediately force IDLE, ptr = 0, remaining = 0, words_written = 0, ld_done = 0, ld_ready = 0, mem_we = 0, cpu_stall = 0.
REQ-030 Words already written before a mid-burst reset shall remain in memory; the arbiter performs no memory clear.

Verification
REQ-031 IDLE, cpu_addr = 3, mem_rdata = 32'h0022202B -> same cycle: cpu_data = 32'h0022202B, mem_addr = 3, cpu_stall = 0, mem_we = 0.
REQ-032 ld_start, base = 0, count = 3; ld_valid high for 3 cycles with data 2001000A / 2002FFFE / FC000000 -> writes at addresses 0, 1, 2; then one-cycle ld_done; words_written = 3; cpu_stall = 0 the cycle after DONE.
REQ-033 base = 1022, count = 4 -> writes at addresses 1022, 1023, 0, 1; words_written = 4.
REQ-034 count = 2 with ld_valid low for 5 cycles between the two words -> exactly 2 writes; cpu_stall high throughout; cpu_data = 0.
REQ-035 rst asserted after 1 of 4 words -> next observation: IDLE, cpu_stall = 0, words_written = 0; address base+0 keeps its written value.
REQ-036 ld_start with count = 0 -> no mem_we; ld_done pulse on the next cycle; ld_start pulsed during LOAD -> burst unaffected.
